// File: rtl/seq_pattern_pkg.sv
// Shared state encoding and default sizing for the serial pattern transmitter.
package seq_pattern_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } stateT;

endpackage

// File: rtl/seq_pattern_shreg.sv
// Loadable MSB-first pattern shift register with bit counter and last-bit flag.
module seq_pattern_shreg
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_nextBit,
    output logic             o_lastBit
);
    localparam int BCW = $clog2(PAT_W);

    logic [PAT_W-1:0] r_shreg;
    logic [BCW-1:0]   r_bitCnt;

    // The MSB is the bit currently on the line; rotating keeps the whole word live.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shreg  <= '0;
            r_bitCnt <= '0;
        end else if (i_load) begin
            r_shreg  <= i_pattern;
            r_bitCnt <= '0;
        end else if (i_shift) begin
            r_shreg  <= {r_shreg[PAT_W-2:0], r_shreg[PAT_W-1]};
            r_bitCnt <= r_bitCnt + BCW'(1);
        end
    end

    assign o_nextBit = r_shreg[PAT_W-2];
    assign o_lastBit = (r_bitCnt == BCW'(PAT_W-1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captured pattern sent MSB-first, repeated with zero-filled gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every repetition.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PAT_W-1:0] req_pattern,
    input  logic [CNT_W-1:0] req_repeat,
    input  logic [GAP_W-1:0] req_gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    stateT            r_state;
    stateT            w_nextState;
    logic [PAT_W-1:0] r_pattern;
    logic [PAT_W-1:0] w_loadValue;
    logic [CNT_W-1:0] r_repCnt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gapCnt;
    logic             r_out;
    logic             r_outValid;
    logic             r_done;
    logic             w_nextOut;
    logic             w_nextOutValid;
    logic             w_nextDone;
    logic             w_capture;
    logic             w_load;
    logic             w_shift;
    logic             w_decRep;
    logic             w_loadGap;
    logic             w_decGap;
    logic             w_nextBit;
    logic             w_lastBit;
    logic             w_repEnd;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic r_parPhase;
    logic w_nextParPhase;

    assign w_repEnd = r_parPhase;
`else
    assign w_repEnd = w_lastBit;
`endif

    seq_pattern_shreg #(.PAT_W(PAT_W)) uShreg (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_pattern (w_loadValue),
        .o_nextBit (w_nextBit),
        .o_lastBit (w_lastBit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic also computes the next registered line values, so out follows accept by one clock.
    always_comb begin
        w_nextState    = r_state;
        w_loadValue    = r_pattern;
        w_nextOut      = 1'b0;
        w_nextOutValid = 1'b0;
        w_nextDone     = 1'b0;
        w_capture      = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_decRep       = 1'b0;
        w_loadGap      = 1'b0;
        w_decGap       = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
        w_nextParPhase = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_capture      = 1'b1;
                    w_load         = 1'b1;
                    w_loadValue    = req_pattern;
                    w_nextOut      = req_pattern[PAT_W-1];
                    w_nextOutValid = 1'b1;
                    w_nextState    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_repEnd) begin
                    if (r_repCnt == '0) begin
                        w_nextDone  = 1'b1;
                        w_nextState = DONE;
                    end else begin
                        w_decRep = 1'b1;
                        if (r_gap == '0) begin
                            w_load         = 1'b1;
                            w_nextOut      = r_pattern[PAT_W-1];
                            w_nextOutValid = 1'b1;
                        end else begin
                            w_loadGap   = 1'b1;
                            w_nextState = GAP;
                        end
                    end
                end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                else if (w_lastBit) begin
                    w_nextOut      = ^r_pattern;
                    w_nextOutValid = 1'b1;
                    w_nextParPhase = 1'b1;
                end
`endif
                else begin
                    w_shift        = 1'b1;
                    w_nextOut      = w_nextBit;
                    w_nextOutValid = 1'b1;
                end
            end
            GAP: begin
                if (r_gapCnt == GAP_W'(1)) begin
                    w_load         = 1'b1;
                    w_nextOut      = r_pattern[PAT_W-1];
                    w_nextOutValid = 1'b1;
                    w_nextState    = SHIFT;
                end else begin
                    w_decGap = 1'b1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out      <= 1'b0;
            r_outValid <= 1'b0;
            r_done     <= 1'b0;
            r_pattern  <= '0;
            r_repCnt   <= '0;
            r_gap      <= '0;
            r_gapCnt   <= '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            r_parPhase <= 1'b0;
`endif
        end else begin
            r_out      <= w_nextOut;
            r_outValid <= w_nextOutValid;
            r_done     <= w_nextDone;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            r_parPhase <= w_nextParPhase;
`endif
            if (w_capture) begin
                r_pattern <= req_pattern;
                r_repCnt  <= req_repeat;
                r_gap     <= req_gap;
            end else if (w_decRep) begin
                r_repCnt <= r_repCnt - CNT_W'(1);
            end
            if (w_loadGap) begin
                r_gapCnt <= r_gap;
            end else if (w_decGap) begin
                r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_outValid;
    assign done      = r_done;
    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a stream-level model predicts every busy cycle of each transfer.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [PAT_W-1:0] req_pattern;
    logic [CNT_W-1:0] req_repeat;
    logic [GAP_W-1:0] req_gap;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int nChecks = 0;
    int nErrors = 0;
    int modelBusy = 0;
    int acceptCnt = 0;
    int detHits = 0;
    int detBase = 0;
    int detN = 0;
    logic [3:0] detSr = '0;
    logic [2:0] expQ[$];
    logic [2:0] monExp;

    logic [PAT_W-1:0] rndPat;
    logic [CNT_W-1:0] rndRep;
    logic [GAP_W-1:0] rndGap;
    logic             rndHold;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_repeat  (req_repeat),
        .req_gap     (req_gap),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle {out, out_valid, done} for a whole transfer, built from the stream rules.
    task automatic buildExpected(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                                 input logic [GAP_W-1:0] gap, output int len);
        int sends;
        sends = int'(rep) + 1;
        len = 0;
        for (int s = 0; s < sends; s++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                expQ.push_back({pat[b], 1'b1, 1'b0});
                len++;
            end
            if (PARITY) begin
                expQ.push_back({^pat, 1'b1, 1'b0});
                len++;
            end
            if (s < sends - 1) begin
                for (int g = 0; g < int'(gap); g++) begin
                    expQ.push_back(3'b000);
                    len++;
                end
            end
        end
        expQ.push_back(3'b001);
        len++;
    endtask

    // Reference model: accepts when it believes the block is idle and counts down the busy window.
    always @(posedge clk or negedge rstn) begin
        int len;
        if (!rstn) begin
            expQ.delete();
            modelBusy = 0;
        end else if (modelBusy == 0) begin
            if (req_valid) begin
                buildExpected(req_pattern, req_repeat, req_gap, len);
                modelBusy = len;
                acceptCnt++;
            end
        end else begin
            modelBusy--;
        end
    end

    // Monitor: every cycle compares handshake and line outputs against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            checkOutput("req_ready", 32'(req_ready), 32'(modelBusy == 0));
            checkOutput("busy", 32'(busy), 32'(modelBusy != 0));
            if (modelBusy != 0) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard underflow", 32'(1), 32'(0));
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("out/out_valid/done", 32'({out, out_valid, done}), 32'(monExp));
                end
            end else begin
                checkOutput("idle out/out_valid/done", 32'({out, out_valid, done}), 32'(0));
            end
            if (out_valid) begin
                detSr = {detSr[2:0], out};
                if (detN < 4) detN++;
                if (detN >= 4 && detSr == 4'b1011) detHits++;
            end
        end
    end

    task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                                 input logic [GAP_W-1:0] gap, input logic keepValid);
        int acc0;
        @(negedge clk);
        req_pattern = pat;
        req_repeat  = rep;
        req_gap     = gap;
        req_valid   = 1'b1;
        acc0 = acceptCnt;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (acceptCnt != acc0) break;
        end
        if (acceptCnt == acc0) checkOutput("accept timeout", 32'(0), 32'(1));
        if (!keepValid) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 1000 && modelBusy != 0; i++) @(negedge clk);
        if (modelBusy != 0) checkOutput("idle timeout", 32'(modelBusy), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        rstn        = 1'b0;
        req_valid   = 1'b0;
        req_pattern = '0;
        req_repeat  = '0;
        req_gap     = '0;

        #23;
        checkOutput("reset out", 32'(out), 32'(0));
        checkOutput("reset out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset busy", 32'(busy), 32'(0));
        checkOutput("reset req_ready", 32'(req_ready), 32'(1));
        #4 rstn = 1'b1;

        applyStimulus(4'b1011, 4'd0, 3'd0, 1'b0);
        waitIdle();

        detBase = detHits;
        applyStimulus(4'b1011, 4'd2, 3'd0, 1'b0);
        waitIdle();
        checkOutput("1011 detections", 32'(detHits - detBase), 32'(3));

        applyStimulus(4'b1011, 4'd1, 3'd3, 1'b0);
        waitIdle();

        applyStimulus(4'b1011, 4'd1, 3'd2, 1'b1);
        applyStimulus(4'b0110, 4'd0, 3'd1, 1'b0);
        waitIdle();

        applyStimulus(4'b1101, 4'd3, 3'd1, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async reset out", 32'(out), 32'(0));
        checkOutput("async reset out_valid", 32'(out_valid), 32'(0));
        checkOutput("async reset busy", 32'(busy), 32'(0));
        checkOutput("async reset done", 32'(done), 32'(0));
        checkOutput("async reset req_ready", 32'(req_ready), 32'(1));
        @(posedge clk);
        #3 rstn = 1'b1;

        applyStimulus(4'b1011, 4'd0, 3'd0, 1'b0);
        waitIdle();
        applyStimulus(4'b1011, 4'd1, 3'd1, 1'b0);
        waitIdle();
        applyStimulus(4'b1001, 4'd15, 3'd0, 1'b0);
        waitIdle();
        applyStimulus(4'b0111, 4'd15, 3'd7, 1'b0);
        waitIdle();

        for (int k = 0; k < 25; k++) begin
            rndPat  = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            rndRep  = ($urandom_range(0, 7) == 0) ? CNT_W'(15) : CNT_W'($urandom_range(0, 3));
            rndGap  = GAP_W'($urandom_range(0, 7));
            rndHold = 1'($urandom_range(0, 1));
            applyStimulus(rndPat, rndRep, rndGap, rndHold);
            if (!rndHold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        req_valid = 1'b0;
        waitIdle();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
